regfile_2r1w: RTL

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parameterised register file with one write port and two
// registered read ports, plus a self-timed clear sweep that zeroes every
// register one entry per cycle (entered on reset or on clear_req_i).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation: writes accepted, reads served from storage
// ST_CLEAR | sweep running: register[cnt_q] zeroed each cycle, busy_o = 1,
//          | writes dropped, reads return zero
module regfile_2r1w #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req_i,
  output logic            busy_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            re_a_i,
  input  logic [AW-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic            re_b_i,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  // One extra bit so NREGS itself is representable when it is a power of two.
  localparam logic [AW:0]   NREGS_W  = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] rdata_a_q, rdata_a_d;
  logic [XLEN-1:0] rdata_b_q, rdata_b_d;
  logic            wr_en;
  logic            busy_q;

  // Address is backed by real storage (non-power-of-two NREGS leaves holes).
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREGS_W);
  endfunction

  // Address reads as constant zero and ignores writes.
  function automatic logic addr_is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  assign busy_q = (state_q == ST_CLEAR);
  assign busy_o = busy_q;

  // A write lands only in IDLE, with no competing clear, to a writable address.
  always_comb begin
    wr_en = 1'b0;
    if (we_i && !busy_q && !clear_req_i &&
        addr_in_range(waddr_i) && !addr_is_zero_reg(waddr_i)) begin
      wr_en = 1'b1;
    end
  end

  // Read value for one port: zero while sweeping or for non-storage
  // addresses, the incoming write data when it targets the same address
  // this cycle (write-first), otherwise the stored value.
  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (busy_q) begin
      val = '0;
    end else if (!addr_in_range(addr) || addr_is_zero_reg(addr)) begin
      val = '0;
    end else if (wr_en && (waddr_i == addr)) begin
      val = wdata_i;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  // FSM next-state: IDLE enters CLEAR on request; CLEAR walks cnt to the last
  // register and returns to IDLE. Requests during CLEAR are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register; reset (re)starts the sweep from register 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage update: sweep zeroing has the port to itself; otherwise a
  // qualified write. Storage itself is not reset, the sweep clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy_q) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

  // Read-port next values: load on enable, hold otherwise.
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (re_a_i) begin
      rdata_a_d = read_mux(raddr_a_i);
    end
    if (re_b_i) begin
      rdata_b_d = read_mux(raddr_b_i);
    end
  end

  // Read-port output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule
